// File: rtl/merge_out_writer_pkg.sv
// Shared definitions for the merge-tree output writer.
// - FSM state encodings (IDLE=0, RUN=1, DONE=2)
// - Helper functions for beats per merged word and the byte step per beat
package merge_out_writer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Number of bus beats needed to carry one merged word.
  function automatic int unsigned calc_beats(input int unsigned p,
                                             input int unsigned data_width,
                                             input int unsigned bus_width);
    return (p * data_width) / bus_width;
  endfunction

  // Byte-address increment between consecutive beats.
  function automatic int unsigned calc_bstep(input int unsigned bus_width);
    return bus_width / 8;
  endfunction

endpackage

// File: rtl/writer_word_fifo.sv
// Registered circular buffer holding merged words awaiting serialisation.
// Ports:
//   i_clk, i_rst_n    clock, async active-low reset (pointers/count only)
//   i_enq, i_data     push a word (ignored when full)
//   i_deq             pop the head word (ignored when empty)
//   o_data            head word (combinational read of the registered storage)
//   o_count           occupancy, 0..DEPTH
//   o_full, o_empty   occupancy flags
module writer_word_fifo
  import merge_out_writer_pkg::*;
#(
  parameter int unsigned WIDTH = 2048,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enq,
  input  logic             i_deq,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_enq;
  logic             w_deq;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_enq = i_enq & ~o_full;
  assign w_deq = i_deq & ~o_empty;

  // Storage deliberately has no reset.
  always_ff @(posedge i_clk) begin
    if (w_enq) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/merge_out_writer.sv
// Root sink of a merger tree: buffers merged words and writes each one to
// memory as a sequence of BUS_WIDTH beats at incrementing byte addresses.
// Ports:
//   i_clk, i_rst_n               clock, async active-low reset
//   i_start, i_base_addr,
//   i_num_words                  run launch (honoured only when idle)
//   i_data, i_write, o_ready     merged-word input handshake
//   o_mem_data, o_mem_addr,
//   o_mem_valid, i_mem_ready     memory write port (valid/ready)
//   o_busy, o_done               run status; o_done pulses after final beat
module merge_out_writer
  import merge_out_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned P          = 16,
  parameter int unsigned BUS_WIDTH  = 512,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [ADDR_WIDTH-1:0]   i_base_addr,
  input  logic [CNT_WIDTH-1:0]    i_num_words,
  input  logic [P*DATA_WIDTH-1:0] i_data,
  input  logic                    i_write,
  output logic                    o_ready,
  output logic [BUS_WIDTH-1:0]    o_mem_data,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic                    o_mem_valid,
  input  logic                    i_mem_ready,
  output logic                    o_busy,
  output logic                    o_done
);

  localparam int unsigned WORD_W = P * DATA_WIDTH;
  localparam int unsigned BEATS  = calc_beats(P, DATA_WIDTH, BUS_WIDTH);
  localparam int unsigned BSTEP  = calc_bstep(BUS_WIDTH);
  localparam int unsigned BIDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned FCW    = $clog2(DEPTH) + 1;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_WIDTH-1:0]  r_words_in;
  logic [CNT_WIDTH-1:0]  r_words_out;
  logic [BIDX_W-1:0]     r_beat_idx;

  logic [WORD_W-1:0]     w_fifo_data;
  logic [FCW-1:0]        w_fifo_count;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_run;
  logic                  w_enq;
  logic                  w_xfer;
  logic                  w_last_beat;
  logic                  w_deq;
  logic [BUS_WIDTH-1:0]  w_mem_data;

  assign w_run       = (r_state == ST_RUN);
  // Ready depends only on registered state: a dequeue that frees a slot
  // this cycle is only visible next cycle.
  assign o_ready     = w_run & ~w_fifo_full & (r_words_in != '0);
  assign o_mem_valid = w_run & ~w_fifo_empty;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_mem_addr  = r_addr;
  assign o_mem_data  = w_mem_data;

  assign w_enq       = i_write & o_ready;
  assign w_xfer      = o_mem_valid & i_mem_ready;
  assign w_last_beat = (r_beat_idx == BIDX_W'(BEATS - 1));
  assign w_deq       = w_xfer & w_last_beat;

  writer_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_enq   (w_enq),
    .i_deq   (w_deq),
    .i_data  (i_data),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Beat 0 carries the least-significant slice of the head word.
  always_comb begin
    w_mem_data = w_fifo_data[BUS_WIDTH-1:0];
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (r_beat_idx == BIDX_W'(b)) w_mem_data = w_fifo_data[b*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_words_in  <= '0;
      r_words_out <= '0;
      r_beat_idx  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_addr      <= i_base_addr;
            r_words_in  <= i_num_words;
            r_words_out <= i_num_words;
            r_beat_idx  <= '0;
            r_state     <= (i_num_words == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_enq) r_words_in <= r_words_in - CNT_WIDTH'(1);
          if (w_xfer) begin
            r_addr <= r_addr + ADDR_WIDTH'(BSTEP);
            if (w_last_beat) begin
              r_beat_idx  <= '0;
              r_words_out <= r_words_out - CNT_WIDTH'(1);
              if (r_words_out == CNT_WIDTH'(1)) r_state <= ST_DONE;
            end else begin
              r_beat_idx <= r_beat_idx + BIDX_W'(1);
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Occupancy count and empty flag must agree.
  a_count_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (w_fifo_count == '0) == w_fifo_empty);

endmodule

// File: tb/tb_merge_out_writer.sv
module tb_merge_out_writer;

  localparam int unsigned DW    = 128;
  localparam int unsigned P     = 16;
  localparam int unsigned BW    = 512;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 64;
  localparam int unsigned CW    = 32;
  localparam int unsigned WW    = P * DW;
  localparam int unsigned BEATS = WW / BW;
  localparam int unsigned BSTEP = BW / 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic [AW-1:0] i_base_addr;
  logic [CW-1:0] i_num_words;
  logic [WW-1:0] i_data;
  logic          i_write;
  logic          o_ready;
  logic [BW-1:0] o_mem_data;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_valid;
  logic          i_mem_ready;
  logic          o_busy;
  logic          o_done;

  always #5 clk = ~clk;

  merge_out_writer #(
    .DATA_WIDTH (DW),
    .P          (P),
    .BUS_WIDTH  (BW),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .CNT_WIDTH  (CW)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_num_words (i_num_words),
    .i_data      (i_data),
    .i_write     (i_write),
    .o_ready     (o_ready),
    .o_mem_data  (o_mem_data),
    .o_mem_addr  (o_mem_addr),
    .o_mem_valid (o_mem_valid),
    .i_mem_ready (i_mem_ready),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned g_acc_at_stall;
  int unsigned g_done_cnt;

  logic [BW-1:0] exp_data_q[$];
  logic [AW-1:0] exp_addr_q[$];

  function automatic logic [WW-1:0] rand_word();
    logic [WW-1:0] w;
    for (int i = 0; i < WW / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  // Drives one run and checks every cycle against a transaction-level model:
  // words accepted, beats delivered, buffer occupancy = accepted - completed.
  task automatic stream(input int unsigned nw, input logic [AW-1:0] base,
                        input int unsigned rdy_pct, input int unsigned wr_pct,
                        input bit offer_always, input bit inject_start,
                        input int unsigned stall_cycles);
    int unsigned   acc = 0;
    int unsigned   beats = 0;
    int unsigned   total;
    int unsigned   cyc = 0;
    bit            fin_prev = 0;
    bit            done_seen = 0;
    bit            prev_stall = 0;
    bit            rdy;
    bit            exp_ready;
    bit            exp_valid;
    logic [BW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    logic [WW-1:0] word;
    logic [AW-1:0] push_addr;
    logic [BW-1:0] ed;
    logic [AW-1:0] ea;
    total = nw * BEATS;
    push_addr = base;
    exp_data_q.delete();
    exp_addr_q.delete();
    g_acc_at_stall = 0;
    g_done_cnt = 0;
    word = rand_word();
    i_start = 1'b1; i_base_addr = base; i_num_words = nw;
    @(negedge clk);
    i_start = 1'b0;
    while (!done_seen && cyc < 3000) begin
      n_checks++;
      if (o_done !== fin_prev) $display("FAIL done_timing cyc=%0d: got %b expected %b", cyc, o_done, fin_prev);
      else n_pass++;
      if (o_done === 1'b1) g_done_cnt++;
      if (fin_prev) done_seen = 1;
      fin_prev = 0;
      n_checks++;
      if (o_busy !== 1'b1) $display("FAIL busy_in_run cyc=%0d: got %b expected 1", cyc, o_busy);
      else n_pass++;
      exp_ready = (beats < total) && ((acc - beats / BEATS) < DEPTH) && (acc < nw);
      exp_valid = (beats < total) && (acc * BEATS > beats);
      n_checks++;
      if (o_ready !== exp_ready) $display("FAIL ready cyc=%0d: got %b expected %b", cyc, o_ready, exp_ready);
      else n_pass++;
      n_checks++;
      if (o_mem_valid !== exp_valid) $display("FAIL mem_valid cyc=%0d: got %b expected %b", cyc, o_mem_valid, exp_valid);
      else n_pass++;
      if (prev_stall) begin
        n_checks++;
        if (o_mem_data !== prev_data || o_mem_addr !== prev_addr)
          $display("FAIL stall_stable cyc=%0d: got addr %h expected %h", cyc, o_mem_addr, prev_addr);
        else n_pass++;
      end
      if (cyc == stall_cycles) g_acc_at_stall = acc;
      rdy = (cyc >= stall_cycles) && ($urandom_range(99) < rdy_pct);
      i_mem_ready = rdy;
      if (exp_valid && rdy && exp_data_q.size() > 0) begin
        ed = exp_data_q.pop_front();
        ea = exp_addr_q.pop_front();
        n_checks++;
        if (o_mem_addr !== ea) $display("FAIL beat_addr beat=%0d: got %h expected %h", beats, o_mem_addr, ea);
        else n_pass++;
        n_checks++;
        if (o_mem_data !== ed) $display("FAIL beat_data beat=%0d: got %h expected %h", beats, o_mem_data, ed);
        else n_pass++;
        beats++;
        if (beats == total) fin_prev = 1;
      end
      prev_stall = exp_valid && !rdy;
      prev_data  = o_mem_data;
      prev_addr  = o_mem_addr;
      i_write = 1'b0;
      if (acc < nw && $urandom_range(99) < wr_pct) begin
        if (exp_ready) begin
          i_write = 1'b1;
          i_data  = word;
          for (int b = 0; b < BEATS; b++) begin
            exp_data_q.push_back(word[b*BW +: BW]);
            exp_addr_q.push_back(push_addr);
            push_addr = push_addr + AW'(BSTEP);
          end
          acc++;
          word = rand_word();
        end else if (offer_always) begin
          i_write = 1'b1;
          i_data  = ~word;
        end
      end
      i_start = 1'b0;
      if (inject_start && beats < total && $urandom_range(3) == 0) begin
        i_start     = 1'b1;
        i_base_addr = {$urandom(), $urandom()};
        i_num_words = $urandom_range(1, 7);
      end
      @(negedge clk);
      cyc++;
    end
    i_write = 1'b0; i_start = 1'b0; i_mem_ready = 1'b0;
    n_checks++;
    if (!done_seen) $display("FAIL run_timeout: got %0d beats expected %0d", beats, total);
    else n_pass++;
    n_checks++;
    if (g_done_cnt != 1) $display("FAIL done_count: got %0d expected 1", g_done_cnt);
    else n_pass++;
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) $display("FAIL back_to_idle: got busy=%b done=%b expected 0 0", o_busy, o_done);
    else n_pass++;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({o_ready, o_mem_valid, o_busy, o_done} !== 4'b0 || o_mem_addr !== '0)
      $display("FAIL reset_outputs: got rdy=%b val=%b busy=%b done=%b addr=%h expected all 0",
               o_ready, o_mem_valid, o_busy, o_done, o_mem_addr);
    else n_pass++;
  endtask

  task automatic test_streaming();
    stream(2, 64'h1000, 100, 100, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    stream(6, 64'h8000, 100, 100, 0, 0, 20);
    n_checks++;
    if (g_acc_at_stall != DEPTH) $display("FAIL bp_accepted: got %0d expected %0d", g_acc_at_stall, DEPTH);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    // Buffer fills during the stall; writes stay offered while the drain starts.
    stream(6, 64'h0001_0000, 100, 100, 1, 0, 8);
  endtask

  task automatic test_zero_length();
    i_start = 1'b1; i_base_addr = 64'h5000; i_num_words = '0;
    @(negedge clk);
    i_start = 1'b0;
    n_checks++;
    if (o_done !== 1'b1 || o_mem_valid !== 1'b0 || o_ready !== 1'b0)
      $display("FAIL zero_len_done: got done=%b val=%b rdy=%b expected 1 0 0", o_done, o_mem_valid, o_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_mem_valid !== 1'b0 || o_ready !== 1'b0)
      $display("FAIL zero_len_idle: got done=%b busy=%b val=%b rdy=%b expected 0 0 0 0",
               o_done, o_busy, o_mem_valid, o_ready);
    else n_pass++;
  endtask

  task automatic test_protocol_violations();
    stream(8, 64'h0002_0040, 70, 80, 1, 1, 0);
  endtask

  task automatic test_pointer_wrap();
    logic [AW-1:0] b;
    b = {$urandom(), $urandom()};
    b[5:0] = '0;
    stream(10, b, 50, 70, 0, 0, 0);
  endtask

  task automatic test_addr_wrap();
    stream(2, 64'hFFFF_FFFF_FFFF_FF80, 80, 100, 0, 0, 0);
  endtask

  task automatic test_reset_mid_run();
    i_start = 1'b1; i_base_addr = 64'h2000; i_num_words = 4;
    @(negedge clk);
    i_start = 1'b0;
    n_checks++;
    if (o_ready !== 1'b1) $display("FAIL mid_rst_ready: got %b expected 1", o_ready);
    else n_pass++;
    i_write = 1'b1; i_data = rand_word(); i_mem_ready = 1'b1;
    @(negedge clk);
    i_write = 1'b0;
    n_checks++;
    if (o_mem_valid !== 1'b1 || o_mem_addr !== 64'h2000)
      $display("FAIL mid_rst_first_beat: got val=%b addr=%h expected 1 2000", o_mem_valid, o_mem_addr);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (o_mem_addr !== 64'h2080) $display("FAIL mid_rst_two_beats: got %h expected 2080", o_mem_addr);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_ready, o_mem_valid, o_busy, o_done} !== 4'b0 || o_mem_addr !== '0)
      $display("FAIL mid_rst_async: got rdy=%b val=%b busy=%b done=%b addr=%h expected all 0",
               o_ready, o_mem_valid, o_busy, o_done, o_mem_addr);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) $display("FAIL mid_rst_hold: got done=%b busy=%b expected 0 0", o_done, o_busy);
      else n_pass++;
    end
    rst_n = 1'b1;
    i_mem_ready = 1'b0;
    @(negedge clk);
    stream(3, 64'h3000, 90, 90, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    i_start = 1'b0; i_base_addr = '0; i_num_words = '0;
    i_data = '0; i_write = 1'b0; i_mem_ready = 1'b0;
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_zero_length();
    test_protocol_violations();
    test_pointer_wrap();
    test_addr_wrap();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
